// File: rtl/ins_issue_ctrl_if.sv
// Code-memory fetch port and processing-stage command port of the 8051 issue controller.
interface ins_issue_ctrl_if;
  logic [7:0]  code_data;
  logic        code_valid;
  logic        pro_ready;
  logic        code_req;
  logic [15:0] code_addr;
  logic [1:0]  process_type;
  logic        alu_en;
  logic [4:0]  alu_op;
  logic [7:0]  imm;
  logic        ID_ready;
  logic        illegal;

  modport master (
    input  code_data, code_valid, pro_ready,
    output code_req, code_addr, process_type, alu_en, alu_op, imm, ID_ready, illegal
  );

  modport slave (
    output code_data, code_valid, pro_ready,
    input  code_req, code_addr, process_type, alu_en, alu_op, imm, ID_ready, illegal
  );
endinterface

// File: rtl/ins_issue_ctrl.sv
// 8051 fetch/decode/issue controller: fetches 1-3 code bytes, decodes a subset,
// issues one command per instruction to the processing stage and resolves SJMP/LJMP.
module ins_issue_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          PIPE_GAP = 2
) (
  input logic              clk,
  input logic              rst,
  ins_issue_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH_OP, FETCH_B1, FETCH_B2, ISSUE, GAP} state_t;

  typedef struct packed {
    logic [1:0] ptype;
    logic [4:0] op;
    logic [1:0] len;
    logic       legal;
  } dec_t;

  localparam logic [7:0] GAP_LAST = 8'((PIPE_GAP > 0) ? PIPE_GAP - 1 : 0);

  // Unsupported opcodes fall through to a 1-byte NOP flagged as illegal.
  function automatic dec_t decode(input logic [7:0] opc);
    dec_t d;
    d = '{2'b00, 5'd0, 2'd1, 1'b1};
    case (opc)
      8'h24:   d = '{2'b01, 5'd1,  2'd2, 1'b1};
      8'h34:   d = '{2'b01, 5'd2,  2'd2, 1'b1};
      8'h94:   d = '{2'b01, 5'd3,  2'd2, 1'b1};
      8'h54:   d = '{2'b01, 5'd4,  2'd2, 1'b1};
      8'h44:   d = '{2'b01, 5'd5,  2'd2, 1'b1};
      8'h64:   d = '{2'b01, 5'd6,  2'd2, 1'b1};
      8'h04:   d = '{2'b01, 5'd7,  2'd1, 1'b1};
      8'h14:   d = '{2'b01, 5'd8,  2'd1, 1'b1};
      8'hF4:   d = '{2'b01, 5'd9,  2'd1, 1'b1};
      8'hE4:   d = '{2'b01, 5'd10, 2'd1, 1'b1};
      8'h74:   d = '{2'b10, 5'd0,  2'd2, 1'b1};
      8'h00:   d = '{2'b00, 5'd0,  2'd1, 1'b1};
      8'h80:   d = '{2'b11, 5'd0,  2'd2, 1'b1};
      8'h02:   d = '{2'b11, 5'd0,  2'd3, 1'b1};
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  state_t             state;
  logic [15:0]        pc;
  logic [7:0]         gap_cnt;
  logic               code_req;
  logic [1:0]         ptype;
  logic               alu_en;
  logic [4:0]         alu_op;
  logic [7:0]         imm;
  logic               id_ready;
  logic               illegal;

  logic [1:0]         ptype_p0;
  logic [4:0]         op_p0;
  logic [1:0]         len_p0;
  logic [7:0]         b1_p0;
  logic [7:0]         b2_p0;
  logic signed [15:0] rel_sx;
  dec_t               dec_in;

  assign dec_in = decode(bus.code_data);
  assign rel_sx = {{8{b1_p0[7]}}, b1_p0};

  // Fetched bytes: opcode decode and operands captured as they arrive
  always_ff @(posedge clk) begin
    if (bus.code_valid) begin
      case (state)
        FETCH_OP: begin
          ptype_p0 <= dec_in.ptype;
          op_p0    <= dec_in.op;
          len_p0   <= dec_in.len;
        end
        FETCH_B1: b1_p0 <= bus.code_data;
        FETCH_B2: b2_p0 <= bus.code_data;
        default: ;
      endcase
    end
  end

  // Control FSM with registered command outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      gap_cnt  <= '0;
      code_req <= 1'b0;
      ptype    <= 2'b00;
      alu_en   <= 1'b0;
      alu_op   <= 5'd0;
      imm      <= 8'd0;
      id_ready <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      id_ready <= 1'b0;
      illegal  <= 1'b0;
      case (state)
        IDLE: begin
          state    <= FETCH_OP;
          code_req <= 1'b1;
        end
        FETCH_OP: if (bus.code_valid) begin
          pc      <= pc + 16'd1;
          illegal <= !dec_in.legal;
          if (dec_in.len == 2'd1) begin
            state    <= ISSUE;
            code_req <= 1'b0;
          end else begin
            state <= FETCH_B1;
          end
        end
        FETCH_B1: if (bus.code_valid) begin
          pc <= pc + 16'd1;
          if (len_p0 == 2'd2) begin
            state    <= ISSUE;
            code_req <= 1'b0;
          end else begin
            state <= FETCH_B2;
          end
        end
        FETCH_B2: if (bus.code_valid) begin
          pc       <= pc + 16'd1;
          state    <= ISSUE;
          code_req <= 1'b0;
        end
        ISSUE: if (bus.pro_ready) begin
          ptype    <= ptype_p0;
          alu_en   <= (ptype_p0 == 2'b01);
          alu_op   <= op_p0;
          imm      <= (len_p0 == 2'd2) ? b1_p0 : 8'd0;
          id_ready <= 1'b1;
          // pc already points past the operands, which is the SJMP base
          if (ptype_p0 == 2'b11)
            pc <= (len_p0 == 2'd2) ? pc + $unsigned(rel_sx) : {b1_p0, b2_p0};
          if (PIPE_GAP == 0) begin
            state    <= FETCH_OP;
            code_req <= 1'b1;
          end else begin
            state   <= GAP;
            gap_cnt <= '0;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state    <= FETCH_OP;
            code_req <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.code_req     = code_req;
  assign bus.code_addr    = pc;
  assign bus.process_type = ptype;
  assign bus.alu_en       = alu_en;
  assign bus.alu_op       = alu_op;
  assign bus.imm          = imm;
  assign bus.ID_ready     = id_ready;
  assign bus.illegal      = illegal;
endmodule
